// File: rtl/cic_integ_decim.sv
// CIC decimator front end: cascaded integrators plus rate reduction.
// Emits one decimated sample with a one-cycle o_ce every RATE inputs.
module cic_integ_decim #(
  parameter  int IW     = 4,
  parameter  int OW     = 12,
  parameter  int STAGES = 3,
  parameter  int RATE   = 8,
  localparam int CW     = $clog2(RATE)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  output logic [OW-1:0] o_data,
  output logic          o_ce,
  output logic [CW-1:0] o_phase
);

  logic [OW-1:0] acc_q [STAGES];
  logic [OW-1:0] acc_d [STAGES];
  logic [CW-1:0] phase_q, phase_d;
  logic [OW-1:0] o_data_q, o_data_d;
  logic          o_ce_q, o_ce_d;
  logic [OW-1:0] data_ext;

  assign data_ext = {{(OW-IW){i_data[IW-1]}}, i_data};

  // Integrator update, phase advance and decimation strobe
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      acc_d[k] = acc_q[k];
    end
    phase_d  = phase_q;
    o_data_d = o_data_q;
    o_ce_d   = 1'b0;
    if (i_ce) begin
      acc_d[0] = acc_q[0] + data_ext;
      for (int k = 1; k < STAGES; k++) begin
        acc_d[k] = acc_q[k] + acc_q[k-1];
      end
      if (phase_q == CW'(RATE - 1)) begin
        phase_d  = '0;
        o_data_d = acc_d[STAGES-1];
        o_ce_d   = 1'b1;
      end else begin
        phase_d = phase_q + CW'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
      end
      phase_q  <= '0;
      o_data_q <= '0;
      o_ce_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
      end
      phase_q  <= phase_d;
      o_data_q <= o_data_d;
      o_ce_q   <= o_ce_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_ce    = o_ce_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_cic_integ_decim.sv
// Bench for cic_integ_decim: three configurations driven in parallel,
// checked against a binomial-convolution reference model.
module tb_cic_integ_decim;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_ce;
  logic [3:0] i_data;

  logic [11:0] od0, od1, od2;
  logic        oc0, oc1, oc2;
  logic [2:0]  op0;
  logic [1:0]  op1, op2;

  always #5 clk = ~clk;

  // default: STAGES=3 RATE=8
  cic_integ_decim u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
    .o_data(od0), .o_ce(oc0), .o_phase(op0)
  );

  cic_integ_decim #(.STAGES(3), .RATE(4)) u_s3r4 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
    .o_data(od1), .o_ce(oc1), .o_phase(op1)
  );

  cic_integ_decim #(.STAGES(1), .RATE(4)) u_s1r4 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
    .o_data(od2), .o_ce(oc2), .o_phase(op2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cfg_s [3] = '{3, 3, 1};
  int cfg_r [3] = '{8, 4, 4};
  int hist [$];
  int n_smp;
  int exp_d [3];
  int exp_c [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // output after n samples: sum x[m]*C(n-m, S-1), modulo 2^12
  function automatic int ref_y(input int s, input int n);
    longint sum = 0;
    for (int m = 1; m <= n; m++) sum += longint'(hist[m-1]) * binom(n - m, s - 1);
    return int'(sum & 64'hFFF);
  endfunction

  task automatic step(input bit rst, input bit ce, input int d);
    int obs_d [3];
    int obs_c [3];
    int obs_p [3];
    i_reset = rst;
    i_ce    = ce;
    i_data  = 4'(d);
    @(posedge clk);
    #1;
    if (rst) begin
      n_smp = 0;
      hist.delete();
      for (int k = 0; k < 3; k++) begin
        exp_d[k] = 0;
        exp_c[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) exp_c[k] = 0;
      if (ce) begin
        hist.push_back(d);
        n_smp++;
        for (int k = 0; k < 3; k++) begin
          if (n_smp % cfg_r[k] == 0) begin
            exp_c[k] = 1;
            exp_d[k] = ref_y(cfg_s[k], n_smp);
          end
        end
      end
    end
    obs_d = '{int'(od0), int'(od1), int'(od2)};
    obs_c = '{int'(oc0), int'(oc1), int'(oc2)};
    obs_p = '{int'(op0), int'(op1), int'(op2)};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_data@%0d", k, n_smp), obs_d[k], exp_d[k]);
      check($sformatf("d%0d_ce@%0d", k, n_smp), obs_c[k], exp_c[k]);
      check($sformatf("d%0d_phase@%0d", k, n_smp), obs_p[k], n_smp % cfg_r[k]);
    end
  endtask

  int prev;
  int rd;

  initial begin
    i_reset = 1'b1;
    i_ce    = 1'b0;
    i_data  = '0;

    // reset held with active inputs
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5);

    // impulse
    step(1'b0, 1'b1, 1);
    for (int i = 2; i <= 12; i++) begin
      step(1'b0, 1'b1, 0);
      if (i == 4)  check("imp_s3r4_4", int'(od1), 3);
      if (i == 8)  check("imp_s3r4_8", int'(od1), 21);
      if (i == 12) check("imp_s3r4_12", int'(od1), 55);
    end

    // DC on every clock
    step(1'b1, 1'b0, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 1);
      if (i % 4 == 0) check("dc_s1r4", int'(od2), i);
    end

    // gapped i_ce, every third clock
    step(1'b1, 1'b0, 0);
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, (i % 3) == 0, 2);
      if (i == 13) check("gap_s1r4_a", int'(od2), 8);
      if (i == 25 - 1) check("gap_s1r4_b", int'(od2), 16);
    end

    // wrap-around with a comb difference across the wrap
    step(1'b1, 1'b0, 0);
    prev = 0;
    for (int i = 1; i <= 296; i++) begin
      step(1'b0, 1'b1, 7);
      if (i == 292) check("wrap_pre", int'(od2), 2044);
      if (i % 4 == 0) begin
        check("wrap_comb", int'((od2 - 12'(prev)) & 12'hFFF), 28);
        prev = int'(od2);
      end
    end
    check("wrap_post", int'($signed(od2)), -2024);

    // reset in the middle of a frame
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 3);
    check("mid_phase", int'(op0), 2);
    step(1'b1, 1'b1, 3);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, -1);
    check("mid_ce", int'(oc0), 1);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rd = $urandom_range(0, 15) - 8;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
